mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM pipeline stage directly downstream of EX. Passes ALU results (waddr/we/wdata) to WB
//  and executes load/store instructions over a single-master req/ack data bus. Stalls the
//  upstream pipeline while a bus access is outstanding. Flags misaligned and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles BUSY may wait for bus_ack_i before aborting with a bus error (1..255)
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   reset, synchronous, active-high
//  ex_valid_i    in   1   EX presents a valid instruction this cycle
//  ex_waddr_i    in   5   destination register address
//  ex_we_i       in   1   register write enable from EX
//  ex_wdata_i    in   32  ALU result (used when memop = NONE)
//  ex_memop_i    in   3   000 NONE, 001 LW, 010 LB, 011 LBU, 100 SW, 101 SB; others = NONE
//  ex_memaddr_i  in   32  effective byte address
//  ex_memdata_i  in   32  store data (SB uses bits 7:0)
//  stallreq_o    out  1   combinational; upstream holds all ex_* inputs while high
//  bus_req_o     out  1   bus request, held until ack or abort
//  bus_we_o      out  1   1 = write
//  bus_addr_o    out  32  word address {addr[31:2],2'b00}
//  bus_sel_o     out  4   byte-lane enables, bit3 = bits 31:24
//  bus_wdata_o   out  32  write data
//  bus_rdata_i   in   32  read data, valid when bus_ack_i high
//  bus_ack_i     in   1   one-cycle completion strobe
//  wb_valid_o    out  1   WB outputs valid this cycle
//  wb_waddr_o    out  5   to WB
//  wb_we_o       out  1   to WB
//  wb_wdata_o    out  32  to WB
//  exc_o         out  2   00 none, 01 misaligned load, 10 misaligned store, 11 bus timeout
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, every registered output 0 (bus_req_o, bus_we_o,
//    bus_addr_o, bus_sel_o, bus_wdata_o, wb_*, exc_o). Reset mid-access drops bus_req_o next
//    edge; outstanding transaction is abandoned, no WB write.
//  - FSM states IDLE, BUSY.
//  - IDLE, ex_valid_i=0: next cycle wb_valid_o=0, wb_we_o=0, exc_o=00.
//  - IDLE, valid, memop NONE: 1-cycle latency; wb_* <= ex_* inputs, exc_o=00. stallreq_o=0.
//  - IDLE, valid, misaligned (LW/SW with addr[1:0]!=0): no bus access; next cycle wb_valid_o=1,
//    wb_we_o=0, exc_o=01 (LW) / 10 (SW). stallreq_o=0. LB/LBU/SB never misaligned.
//  - IDLE, valid, aligned memop: stallreq_o=1 this cycle; at edge go BUSY, assert bus_req_o,
//    drive bus_addr/we/sel/wdata, latch waddr/we/memop/addr[1:0], clear counter.
//  - Lanes (big-endian): word: sel 1111. byte: addr[1:0]=0->1000, 1->0100, 2->0010, 3->0001.
//    SB replicates data byte into all four lanes of bus_wdata_o.
//  - BUSY: ex_* inputs ignored. stallreq_o = !bus_ack_i. Counter increments each cycle without ack.
//  - BUSY, bus_ack_i=1: at edge bus_req_o=0, state IDLE, wb_valid_o=1, exc_o=00.
//    LW: wb_wdata_o=rdata, wb_we_o=latched we. LB: selected byte sign-extended; LBU: zero-extended.
//    SW/SB: wb_we_o=0, wb_wdata_o=0.
//  - BUSY, counter reaches TIMEOUT_CYC without ack: at edge bus_req_o=0, state IDLE, wb_valid_o=1,
//    wb_we_o=0, exc_o=11; stallreq_o=0 in that final cycle.
//  - bus_ack_i while IDLE (late/spurious) is ignored.
//  - Bus outputs stable for entire BUSY period; wb_valid_o and exc_o are one-cycle pulses.
// TESTING
//  1 memop NONE, waddr=3, we=1, wdata=0x1234_5678 -> next cycle wb_valid=1, wb_waddr=3, wb_wdata=0x12345678, stallreq never high.
//  2 LB addr=0x101, ack after 3 cycles, rdata=0x0080_0000 -> sel=0100, stallreq high 3 cycles, wb_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  3 SB addr=0x203 data=0xAB -> bus_addr=0x200, sel=0001, wdata=0xABAB_ABAB, we=1; after ack wb_we=0.
//  4 LW addr=0x102 -> no bus_req, stallreq=0, next cycle wb_valid=1, wb_we=0, exc_o=01.
//  5 TIMEOUT_CYC=4, LW aligned, no ack -> bus_req dropped after 4 BUSY cycles, exc_o=11 one cycle; later stray ack ignored.
//  6 rst asserted in 2nd BUSY cycle -> next cycle bus_req=0, all outputs 0, state IDLE; following NONE op completes normally.

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: forwards ALU results to WB and runs loads/stores over a
// single-master req/ack bus, stalling EX while an access is outstanding.
module mem_access #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [4:0]  ex_waddr_i,
   input  logic        ex_we_i,
   input  logic [31:0] ex_wdata_i,
   input  logic [2:0]  ex_memop_i,
   input  logic [31:0] ex_memaddr_i,
   input  logic [31:0] ex_memdata_i,
   output logic        stallreq_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_waddr_o,
   output logic        wb_we_o,
   output logic [31:0] wb_wdata_o,
   output logic [1:0]  exc_o
);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [2:0] {
      OP_NONE = 3'b000,
      OP_LW   = 3'b001,
      OP_LB   = 3'b010,
      OP_LBU  = 3'b011,
      OP_SW   = 3'b100,
      OP_SB   = 3'b101
   } memop_t;

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   memop_t      l_memop, l_memop_n;
   logic [1:0]  l_off, l_off_n;
   logic [4:0]  l_waddr, l_waddr_n;
   logic        l_we, l_we_n;

   logic        bus_req_n, bus_we_n;
   logic [31:0] bus_addr_n, bus_wdata_n;
   logic [3:0]  bus_sel_n;
   logic        wb_valid_n, wb_we_n;
   logic [4:0]  wb_waddr_n;
   logic [31:0] wb_wdata_n;
   logic [1:0]  exc_n;

   logic        is_lw, is_sw, is_byte, is_mem, misaligned, timeout_hit;
   logic [3:0]  byte_sel;
   logic [7:0]  rd_byte;

   assign is_lw      = (ex_memop_i == OP_LW);
   assign is_sw      = (ex_memop_i == OP_SW);
   assign is_byte    = (ex_memop_i == OP_LB) || (ex_memop_i == OP_LBU) || (ex_memop_i == OP_SB);
   assign is_mem     = is_lw || is_sw || is_byte;
   assign misaligned = (is_lw || is_sw) && (ex_memaddr_i[1:0] != 2'b00);
   assign timeout_hit = (cnt == 8'(TIMEOUT_CYC - 1));

   // Big-endian lanes: byte offset 0 lives in bits 31:24.
   always_comb begin
      byte_sel = 4'b1000;
      case (ex_memaddr_i[1:0])
         2'd0: byte_sel = 4'b1000;
         2'd1: byte_sel = 4'b0100;
         2'd2: byte_sel = 4'b0010;
         2'd3: byte_sel = 4'b0001;
         default: byte_sel = 4'b1000;
      endcase
   end

   always_comb begin
      rd_byte = bus_rdata_i[31:24];
      case (l_off)
         2'd0: rd_byte = bus_rdata_i[31:24];
         2'd1: rd_byte = bus_rdata_i[23:16];
         2'd2: rd_byte = bus_rdata_i[15:8];
         2'd3: rd_byte = bus_rdata_i[7:0];
         default: rd_byte = bus_rdata_i[31:24];
      endcase
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      l_memop_n   = l_memop;
      l_off_n     = l_off;
      l_waddr_n   = l_waddr;
      l_we_n      = l_we;
      stallreq_o  = 1'b0;
      bus_req_n   = bus_req_o;
      bus_we_n    = bus_we_o;
      bus_addr_n  = bus_addr_o;
      bus_sel_n   = bus_sel_o;
      bus_wdata_n = bus_wdata_o;
      wb_valid_n  = 1'b0;
      wb_we_n     = 1'b0;
      wb_waddr_n  = wb_waddr_o;
      wb_wdata_n  = wb_wdata_o;
      exc_n       = 2'b00;

      case (state)
         IDLE: begin
            if (ex_valid_i) begin
               if (misaligned) begin
                  wb_valid_n = 1'b1;
                  wb_waddr_n = ex_waddr_i;
                  exc_n      = is_lw ? 2'b01 : 2'b10;
               end else if (is_mem) begin
                  stallreq_o  = 1'b1;
                  state_n     = BUSY;
                  cnt_n       = '0;
                  bus_req_n   = 1'b1;
                  bus_we_n    = (ex_memop_i == OP_SW) || (ex_memop_i == OP_SB);
                  bus_addr_n  = {ex_memaddr_i[31:2], 2'b00};
                  bus_sel_n   = is_byte ? byte_sel : 4'b1111;
                  bus_wdata_n = (ex_memop_i == OP_SB) ? {4{ex_memdata_i[7:0]}} : ex_memdata_i;
                  l_memop_n   = memop_t'(ex_memop_i);
                  l_off_n     = ex_memaddr_i[1:0];
                  l_waddr_n   = ex_waddr_i;
                  l_we_n      = ex_we_i;
               end else begin
                  wb_valid_n = 1'b1;
                  wb_waddr_n = ex_waddr_i;
                  wb_we_n    = ex_we_i;
                  wb_wdata_n = ex_wdata_i;
               end
            end
         end
         BUSY: begin
            if (bus_ack_i) begin
               state_n    = IDLE;
               bus_req_n  = 1'b0;
               wb_valid_n = 1'b1;
               wb_waddr_n = l_waddr;
               case (l_memop)
                  OP_LW: begin
                     wb_we_n    = l_we;
                     wb_wdata_n = bus_rdata_i;
                  end
                  OP_LB: begin
                     wb_we_n    = l_we;
                     wb_wdata_n = {{24{rd_byte[7]}}, rd_byte};
                  end
                  OP_LBU: begin
                     wb_we_n    = l_we;
                     wb_wdata_n = {24'd0, rd_byte};
                  end
                  default: begin
                     wb_we_n    = 1'b0;
                     wb_wdata_n = '0;
                  end
               endcase
            end else if (timeout_hit) begin
               // Final cycle of an abort: release the stall so EX can move on.
               state_n    = IDLE;
               bus_req_n  = 1'b0;
               wb_valid_n = 1'b1;
               wb_waddr_n = l_waddr;
               exc_n      = 2'b11;
            end else begin
               stallreq_o = 1'b1;
               cnt_n      = cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         l_memop     <= OP_NONE;
         l_off       <= '0;
         l_waddr     <= '0;
         l_we        <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= '0;
         bus_wdata_o <= '0;
         wb_valid_o  <= 1'b0;
         wb_waddr_o  <= '0;
         wb_we_o     <= 1'b0;
         wb_wdata_o  <= '0;
         exc_o       <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         l_memop     <= l_memop_n;
         l_off       <= l_off_n;
         l_waddr     <= l_waddr_n;
         l_we        <= l_we_n;
         bus_req_o   <= bus_req_n;
         bus_we_o    <= bus_we_n;
         bus_addr_o  <= bus_addr_n;
         bus_sel_o   <= bus_sel_n;
         bus_wdata_o <= bus_wdata_n;
         wb_valid_o  <= wb_valid_n;
         wb_waddr_o  <= wb_waddr_n;
         wb_we_o     <= wb_we_n;
         wb_wdata_o  <= wb_wdata_n;
         exc_o       <= exc_n;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: WB results are queued when stimulus is driven
// and checked by a monitor whenever wb_valid_o pulses.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid_i;
   logic [4:0]  ex_waddr_i;
   logic        ex_we_i;
   logic [31:0] ex_wdata_i;
   logic [2:0]  ex_memop_i;
   logic [31:0] ex_memaddr_i;
   logic [31:0] ex_memdata_i;
   logic        stallreq_o;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        wb_valid_o;
   logic [4:0]  wb_waddr_o;
   logic        wb_we_o;
   logic [31:0] wb_wdata_o;
   logic [1:0]  exc_o;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [4:0]  waddr;
      logic        we;
      logic [31:0] wdata;
      logic [1:0]  exc;
      logic        full;
   } exp_t;
   exp_t q[$];

   mem_access #(.TIMEOUT_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_we_i(ex_we_i),
      .ex_wdata_i(ex_wdata_i), .ex_memop_i(ex_memop_i), .ex_memaddr_i(ex_memaddr_i),
      .ex_memdata_i(ex_memdata_i), .stallreq_o(stallreq_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
      .bus_ack_i(bus_ack_i), .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o),
      .wb_we_o(wb_we_o), .wb_wdata_o(wb_wdata_o), .exc_o(exc_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] waddr, input logic we, input logic [31:0] wdata,
                       input logic [1:0] exc, input logic full);
      exp_t e;
      e.waddr = waddr; e.we = we; e.wdata = wdata; e.exc = exc; e.full = full;
      q.push_back(e);
   endtask

   // Scoreboard side: every WB pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && wb_valid_o) begin
         if (q.size() == 0) begin
            chk("wb_unexpected", 32'(wb_valid_o), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("wb_we", 32'(wb_we_o), 32'(e.we));
            chk("wb_exc", 32'(exc_o), 32'(e.exc));
            if (e.full) begin
               chk("wb_waddr", 32'(wb_waddr_o), 32'(e.waddr));
               chk("wb_wdata", wb_wdata_o, e.wdata);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] waddr, input logic we, input logic [31:0] wdata);
      ex_valid_i = 1'b1; ex_memop_i = op; ex_memaddr_i = addr; ex_memdata_i = data;
      ex_waddr_i = waddr; ex_we_i = we; ex_wdata_i = wdata;
   endtask

   // Aligned access acked in BUSY cycle n_wait+1; bus outputs checked every BUSY cycle.
   task automatic mem_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] waddr, input logic we, input int n_wait,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_sel, input logic [31:0] e_wdata,
                         input logic e_bwe, input logic [31:0] e_res, input logic e_we);
      int stalls = 0;
      drive(op, addr, data, waddr, we, 32'h0);
      @(negedge clk);
      if (stallreq_o) stalls++;
      tick();
      for (int c = 0; c <= n_wait; c++) begin
         chk("bus_req", 32'(bus_req_o), 32'd1);
         chk("bus_addr", bus_addr_o, e_addr);
         chk("bus_sel", 32'(bus_sel_o), 32'(e_sel));
         chk("bus_we", 32'(bus_we_o), 32'(e_bwe));
         if (e_bwe) chk("bus_wdata", bus_wdata_o, e_wdata);
         if (c == n_wait) begin
            bus_ack_i = 1'b1;
            bus_rdata_i = rdata;
            push(waddr, e_we, e_res, 2'b00, 1'b1);
         end
         @(negedge clk);
         if (stallreq_o) stalls++;
         tick();
      end
      bus_ack_i = 1'b0;
      bus_rdata_i = 32'h0;
      ex_valid_i = 1'b0;
      chk("bus_req_drop", 32'(bus_req_o), 32'd0);
      chk("stall_cycles", 32'(stalls), 32'(n_wait + 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; ex_valid_i = 1'b0; ex_waddr_i = '0; ex_we_i = 1'b0; ex_wdata_i = '0;
      ex_memop_i = '0; ex_memaddr_i = '0; ex_memdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
      tick(); tick();
      chk("rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_exc", 32'(exc_o), 32'd0);
      chk("rst_bus_addr", bus_addr_o, 32'd0);
      chk("rst_wb_wdata", wb_wdata_o, 32'd0);
      rst = 1'b0;
      tick();

      // Plain ALU result passthrough.
      drive(3'b000, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234_5678);
      push(5'd3, 1'b1, 32'h1234_5678, 2'b00, 1'b1);
      @(negedge clk);
      chk("none_stall", 32'(stallreq_o), 32'd0);
      tick();
      ex_valid_i = 1'b0;
      chk("none_bus_req", 32'(bus_req_o), 32'd0);
      tick();
      chk("pulse_wb_valid", 32'(wb_valid_o), 32'd0);

      // Byte loads at offset 1, signed and unsigned.
      mem_op(3'b010, 32'h101, 32'h0, 5'd5, 1'b1, 2, 32'h0080_0000,
             32'h100, 4'b0100, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1);
      mem_op(3'b011, 32'h101, 32'h0, 5'd6, 1'b1, 2, 32'h0080_0000,
             32'h100, 4'b0100, 32'h0, 1'b0, 32'h0000_0080, 1'b1);
      // Byte store at offset 3 replicates the byte into every lane.
      mem_op(3'b101, 32'h203, 32'h0000_00AB, 5'd7, 1'b1, 1, 32'h0,
             32'h200, 4'b0001, 32'hABAB_ABAB, 1'b1, 32'h0, 1'b0);
      // Word load / store, immediate ack.
      mem_op(3'b001, 32'h104, 32'h0, 5'd8, 1'b1, 0, 32'hDEAD_BEEF,
             32'h104, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
      mem_op(3'b100, 32'h208, 32'h5A5A_0001, 5'd9, 1'b1, 1, 32'h0,
             32'h208, 4'b1111, 32'h5A5A_0001, 1'b1, 32'h0, 1'b0);
      tick();

      // Misaligned word load and store.
      drive(3'b001, 32'h102, 32'h0, 5'd10, 1'b1, 32'h0);
      push(5'd10, 1'b0, 32'h0, 2'b01, 1'b0);
      @(negedge clk);
      chk("mis_lw_stall", 32'(stallreq_o), 32'd0);
      tick();
      chk("mis_lw_bus_req", 32'(bus_req_o), 32'd0);
      drive(3'b100, 32'h201, 32'h0, 5'd11, 1'b1, 32'h0);
      push(5'd11, 1'b0, 32'h0, 2'b10, 1'b0);
      @(negedge clk);
      chk("mis_sw_stall", 32'(stallreq_o), 32'd0);
      tick();
      ex_valid_i = 1'b0;
      chk("mis_sw_bus_req", 32'(bus_req_o), 32'd0);
      tick();

      // Timeout: four BUSY cycles, last one without stall, then abort.
      drive(3'b001, 32'h300, 32'h0, 5'd12, 1'b1, 32'h0);
      @(negedge clk);
      chk("to_stall_idle", 32'(stallreq_o), 32'd1);
      tick();
      for (int c = 1; c <= 4; c++) begin
         chk("to_bus_req", 32'(bus_req_o), 32'd1);
         if (c == 4) push(5'd12, 1'b0, 32'h0, 2'b11, 1'b0);
         @(negedge clk);
         chk("to_stall", 32'(stallreq_o), (c == 4) ? 32'd0 : 32'd1);
         tick();
      end
      ex_valid_i = 1'b0;
      chk("to_bus_req_drop", 32'(bus_req_o), 32'd0);
      bus_ack_i = 1'b1;
      bus_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("stray_stall", 32'(stallreq_o), 32'd0);
      tick();
      bus_ack_i = 1'b0;
      chk("stray_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("stray_exc", 32'(exc_o), 32'd0);
      chk("stray_bus_req", 32'(bus_req_o), 32'd0);

      // Reset during the second BUSY cycle abandons the access.
      drive(3'b001, 32'h400, 32'h0, 5'd13, 1'b1, 32'h0);
      tick();
      tick();
      chk("pre_rst_bus_req", 32'(bus_req_o), 32'd1);
      rst = 1'b1;
      ex_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      chk("mid_rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("mid_rst_bus_sel", 32'(bus_sel_o), 32'd0);
      chk("mid_rst_bus_addr", bus_addr_o, 32'd0);
      chk("mid_rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("mid_rst_stall", 32'(stallreq_o), 32'd0);
      drive(3'b000, 32'h0, 32'h0, 5'd14, 1'b1, 32'hCAFE_F00D);
      push(5'd14, 1'b1, 32'hCAFE_F00D, 2'b00, 1'b1);
      tick();
      ex_valid_i = 1'b0;
      tick();
      tick();
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
